// File: rtl/sipo_frame_rx.sv
// ---------------------------------------------------------------------------
// sipo_frame_rx
//
// Serial frame receiver placed directly after the right-shifting SISO stage.
// It samples the 1-bit line LSB-first on cycles with enb=1 and detects
// start/stop framing. It reassembles DW-bit words into a one-entry output
// buffer that uses a valid/ready handshake.
//
// Line convention: idle = 0, start bit = 1, stop bit = 0.
// Frame: start, DW data bits (LSB first), [parity], stop.
//
// Optional feature (compile-time macro SIPO_FRAME_RX_PARITY_EN):
//   defined   - even parity bit after the data bits (frame length DW+3);
//               a mismatch pulses par_err and discards the frame.
//   undefined - no parity bit (frame length DW+2); par_err tied to 0.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   enb       in   bit strobe; inp is sampled only when enb=1
//   inp       in   serial bit, LSB-first
//   data_out  out  [DW] received word, stable while valid=1
//   valid     out  data_out holds an unconsumed word
//   ready     in   consumer accepts the word when valid=1 and ready=1
//   busy      out  receiver is inside a frame (FSM not IDLE)
//   frm_err   out  1-cycle pulse: stop bit was not 0
//   par_err   out  1-cycle pulse: parity mismatch
//   ovr_err   out  1-cycle pulse: good frame dropped, buffer full
// ---------------------------------------------------------------------------
module sipo_frame_rx #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic          inp,
    output logic [DW-1:0] data_out,
    output logic          valid,
    input  logic          ready,
    output logic          busy,
    output logic          frm_err,
    output logic          par_err,
    output logic          ovr_err
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t        state;
    logic [DW-1:0] shreg;
    logic [CW-1:0] cnt;
    logic          stop_hit;
    logic          bad_par;
    logic          good;

`ifdef SIPO_FRAME_RX_PARITY_EN
    logic par_bit;
    // Even parity over data plus parity bit: any odd total is a mismatch.
    assign bad_par = ^{shreg, par_bit};
`else
    assign bad_par = 1'b0;
    assign par_err = 1'b0;
`endif

    // The outcome is decided on the stop-bit sample; the word in shreg is
    // complete by then because the parity/stop states never shift.
    assign stop_hit = enb && (state == STOP);
    assign good     = stop_hit && !inp && !bad_par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            frm_err  <= 1'b0;
            ovr_err  <= 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
            par_bit  <= 1'b0;
            par_err  <= 1'b0;
`endif
        end else begin
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
            par_err <= 1'b0;
`endif
            if (enb) begin
                case (state)
                    IDLE: begin
                        if (inp) begin
                            state <= DATA;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg <= {inp, shreg[DW-1:1]};
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(DW - 1)) begin
                            cnt   <= '0;
`ifdef SIPO_FRAME_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
`ifdef SIPO_FRAME_RX_PARITY_EN
                    PARITY: begin
                        par_bit <= inp;
                        state   <= STOP;
                    end
`endif
                    STOP: begin
                        // Always back to IDLE: the stop sample is never a start.
                        state   <= IDLE;
                        busy    <= 1'b0;
                        frm_err <= inp;
`ifdef SIPO_FRAME_RX_PARITY_EN
                        par_err <= bad_par;
`endif
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end

            // Output buffer: a consume in the same cycle frees the slot for
            // the new word, so back-to-back words keep valid high.
            if (good) begin
                if (!valid || ready) begin
                    data_out <= shreg;
                    valid    <= 1'b1;
                end else begin
                    ovr_err  <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_sipo_frame_rx
//
// Self-checking bench for sipo_frame_rx (DW=4). It runs four groups of tests:
// reset values, a table of single frames, hand-written multi-cycle sequences
// (overrun, back-to-back, mid-frame reset, parity), and randomized frames
// checked against a frame-level reference model of the output buffer.
// ---------------------------------------------------------------------------
module tb_sipo_frame_rx;

    localparam int DW = 4;
`ifdef SIPO_FRAME_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          enb   = 1'b0;
    logic          inp   = 1'b0;
    logic          ready = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid, busy, frm_err, par_err, ovr_err;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // reference model state
    logic [DW-1:0] md;
    logic          mv, mb;

    sipo_frame_rx #(.DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .inp      (inp),
        .data_out (data_out),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy),
        .frm_err  (frm_err),
        .par_err  (par_err),
        .ovr_err  (ovr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input logic e, input logic b, input logic r);
        enb = e; inp = b; ready = r;
        @(posedge clk);
        #1;
    endtask

    // Send one frame; ready is r on every bit except the stop bit (rstop).
    task automatic tx_frame(input logic [DW-1:0] w, input logic stopb, input bit pok,
                            input logic r, input logic rstop, input bit gaps);
        tick(1'b1, 1'b1, r);
        for (int i = 0; i < DW; i++) begin
            if (gaps) tick(1'b0, ~w[i], r);
            tick(1'b1, w[i], r);
        end
        if (PAR) tick(1'b1, pok ? ^w : ~^w, r);
        tick(1'b1, stopb, rstop);
    endtask

    task automatic check_all(input string tag, input logic [DW-1:0] d, input logic v,
                             input logic b, input logic f, input logic p, input logic o);
        check({tag, "_data"},  32'(data_out), 32'(d));
        check({tag, "_valid"}, 32'(valid),    32'(v));
        check({tag, "_busy"},  32'(busy),     32'(b));
        check({tag, "_frm"},   32'(frm_err),  32'(f));
        check({tag, "_par"},   32'(par_err),  32'(p));
        check({tag, "_ovr"},   32'(ovr_err),  32'(o));
    endtask

    // One cycle of random stimulus, with the frame-level model advanced at the edge.
    // st: this cycle carries the start bit; sp: this cycle carries the stop bit.
    task automatic drive(input logic e, input logic b, input logic r, input bit st, input bit sp,
                         input logic [DW-1:0] w, input bit fe, input bit pe);
        bit xf, xp, xo, ld;
        enb = e; inp = b; ready = r;
        @(posedge clk);
        xf = 1'b0; xp = 1'b0; xo = 1'b0; ld = 1'b0;
        if (st) mb = 1'b1;
        if (sp) begin
            mb = 1'b0;
            xf = fe;
            xp = pe;
            if (!fe && !pe) begin
                if (!mv || r) ld = 1'b1;
                else xo = 1'b1;
            end
        end
        if (ld) begin
            md = w;
            mv = 1'b1;
        end else if (mv && r) begin
            mv = 1'b0;
        end
        #1;
        check_all("rnd", md, mv, mb, xf, xp, xo);
    endtask

    function automatic logic rr();
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic rnd_gaps();
        repeat ($urandom_range(0, 1)) drive(1'b0, 1'($urandom), rr(), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic rnd_frame();
        logic [DW-1:0] w;
        bit fe, pbad;
        w    = DW'($urandom);
        fe   = ($urandom_range(0, 4) == 0);
        pbad = PAR && ($urandom_range(0, 4) == 0);
        repeat ($urandom_range(0, 3)) begin
            if ($urandom_range(0, 1) == 1) drive(1'b1, 1'b0, rr(), 1'b0, 1'b0, '0, 1'b0, 1'b0);
            else drive(1'b0, 1'($urandom), rr(), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b1, rr(), 1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DW; i++) begin
            rnd_gaps();
            drive(1'b1, w[i], rr(), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
        if (PAR) begin
            rnd_gaps();
            drive(1'b1, (^w) ^ pbad, rr(), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
        rnd_gaps();
        drive(1'b1, fe, rr(), 1'b0, 1'b1, w, fe, pbad);
    endtask

    typedef struct {
        logic [DW-1:0] w;
        logic          stopb;
        logic [DW-1:0] exp_d;
        logic          exp_v;
        logic          exp_f;
    } vec_t;

    vec_t vt [6];

    initial begin
        vt = '{
            '{4'hA, 1'b0, 4'hA, 1'b1, 1'b0},
            '{4'hF, 1'b1, 4'hA, 1'b0, 1'b1},
            '{4'h5, 1'b0, 4'h5, 1'b1, 1'b0},
            '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0},
            '{4'h9, 1'b1, 4'h0, 1'b0, 1'b1},
            '{4'hE, 1'b0, 4'hE, 1'b1, 1'b0}
        };

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        check_all("idle", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // table of single frames, ready held high
        for (int k = 0; k < 6; k++) begin
            tick(1'b1, 1'b0, 1'b1);
            tx_frame(vt[k].w, vt[k].stopb, 1'b1, 1'b1, 1'b1, 1'b0);
            check_all("tbl_stop", vt[k].exp_d, vt[k].exp_v, 1'b0, vt[k].exp_f, 1'b0, 1'b0);
            tick(1'b1, 1'b0, 1'b1);
            check("tbl_after_valid", 32'(valid),   32'(0));
            check("tbl_after_frm",   32'(frm_err), 32'(0));
            check("tbl_after_data",  32'(data_out), 32'(vt[k].exp_d));
        end

        // overrun: 3 held, C dropped
        tick(1'b1, 1'b0, 1'b0);
        tx_frame(4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("ovr_first", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tx_frame(4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("ovr_second", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        check_all("ovr_hold", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        check_all("ovr_consume", 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // back-to-back: ready rises exactly on the second stop sample
        tx_frame(4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("b2b_first", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tx_frame(4'hC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_all("b2b_second", 4'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check_all("b2b_hold", 4'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        check("b2b_consume", 32'(valid), 32'(0));

        // reset mid-frame after two data bits
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        check("mid_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        #1;
        check_all("mid_rst", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        tick(1'b1, 1'b0, 1'b1);
        check_all("post_rst", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tx_frame(4'h9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check_all("gap_frame", 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef SIPO_FRAME_RX_PARITY_EN
        // parity: bad parity, good parity, both errors
        tx_frame(4'h7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_all("par_bad", 4'h9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        check("par_pulse_end", 32'(par_err), 32'(0));
        tx_frame(4'h7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_all("par_good", 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tx_frame(4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_all("par_both", 4'h7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
`endif

        // randomized frames against the reference model
        tick(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        md = '0; mv = 1'b0; mb = 1'b0;
        for (int n = 0; n < 150; n++) rnd_frame();
        repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/sipo_frame_rx.md
Name: sipo_frame_rx

Overview:
Serial frame receiver that sits directly downstream of the right-shifting SISO register stage. It consumes the 1-bit serial stream LSB-first on enabled cycles, detects start/stop framing, and reassembles DW-bit words. Completed words are held in a one-entry output buffer with a valid/ready handshake. Framing, parity and overrun errors are reported as single-cycle pulses.

Parameters:
DW, 4, data word width in bits; legal range 2..32.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset; asynchronous, active-high
enb  input  1  bit strobe; inp is sampled only on cycles where enb=1
inp  input  1  serial bit from the upstream SISO stage, LSB-first
data_out  output  DW  received word; stable while valid=1
valid  output  1  data_out holds an unconsumed word
ready  input  1  consumer accepts the word on a cycle with valid=1 and ready=1
busy  output  1  FSM is not in IDLE
frm_err  output  1  one-cycle pulse: stop bit was not 0
par_err  output  1  one-cycle pulse: parity mismatch; constant 0 when the parity feature is compiled out
ovr_err  output  1  one-cycle pulse: completed frame dropped because the buffer was full

Behaviour:
- Reset is asynchronous and active-high on rst. While rst=1: FSM=IDLE, shift register=0, bit counter=0, data_out=0, valid=0, busy=0, frm_err=0, par_err=0, ovr_err=0. Reset mid-frame discards the partial frame and does not raise an error.
- Line convention: idle=0 (upstream resets to zeros), start bit=1, stop bit=0.
- FSM states are IDLE, DATA, PARITY and STOP. Transitions occur only on enb=1 cycles; with enb=0, state, counter and shift register hold.
- IDLE: when inp=1, go to DATA and clear the counter. When inp=0, stay in IDLE.
- DATA: each enb cycle does shreg <= {inp, shreg[DW-1:1]} and increments the counter. After the DW-th bit, go to PARITY (feature on) or STOP (feature off).
- PARITY: sample inp as the parity bit, then go to STOP.
- STOP: sample inp, then always go to IDLE. The stop-bit cycle is never reinterpreted as a start bit.
- Frame outcome, decided on the STOP sample cycle:
  - inp=1: pulse frm_err and discard the frame.
  - Parity mismatch: pulse par_err and discard the frame. If both errors apply, both pulse.
  - Otherwise the frame is good.
- Good-frame latency: valid=1 and the new data_out are registered on the clock edge of the STOP sample. They are visible the cycle after the enb pulse that carried the stop bit.
- Handshake:
  - valid stays 1 until a cycle with ready=1, then clears on the next edge.
  - ready is ignored while valid=0.
  - data_out holds its last value after consumption.
- Simultaneous events when a good frame completes:
  - valid=0: load data_out and set valid=1.
  - valid=1 and ready=1 on the same cycle: load the new word and keep valid=1, so back-to-back words need no bubble.
  - valid=1 and ready=0: drop the new frame, pulse ovr_err, leave data_out/valid unchanged.
- busy = (state != IDLE), registered.
- All error outputs are registered and high for exactly one clk cycle.

Optional Feature:
Macro: SIPO_FRAME_RX_PARITY_EN.
- Defined: the PARITY state exists. Parity is even over the DW data bits plus the parity bit; mismatch means ^{data, parity} = 1. Frame length is DW+3 bits.
- Undefined: the PARITY state and its logic are absent. DATA goes directly to STOP, par_err is tied to 0, and frame length is DW+2 bits.

Test Plan:
All cases use DW=4, enb held at 1, ready=1 unless stated.
1. Basic receive. Hold rst=1, then release; drive idle 0s; send 1,0,1,0,1,[0 parity],0 (4'hA LSB-first) -> after stop, data_out=4'hA, valid=1 for one cycle, busy=0.
2. Framing error. Send 1,1,1,1,1,[0],1 (bad stop) -> frm_err pulse; valid stays 0; FSM returns to IDLE; next good frame for 4'h5 -> data_out=4'h5.
3. Overrun. Set ready=0; send 4'h3 then 4'hC -> 4'h3 held with valid=1; ovr_err pulses at the 4'hC stop; raise ready -> 4'h3 consumed, valid=0.
4. Back-to-back. Set ready=1 exactly on the cycle the second frame's stop is sampled -> data_out switches 4'h3 -> 4'hC with valid continuously 1 and no ovr_err.
5. Enable gaps and reset. With enb toggling 1-0-1, the frame for 4'h9 is still received correctly. Assert rst after 2 data bits -> all outputs 0, no error pulse; the following frame decodes correctly.
6. Parity (macro defined). Send 4'h7 with parity bit 0 -> par_err pulse, no valid. Send 4'h7 with parity bit 1 -> data_out=4'h7, valid=1.
